// File: rtl/img_rsz_div_pkg.sv
// Shared types for the image-resizer divider: FSM states, result flags and datapath width helper.
package img_rsz_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    BUSY,
    DONE
  } div_state_e;

  typedef struct packed {
    logic ovf;
    logic div_zero;
  } div_flags_t;

  // Two guard bits above the widest operand keep the trial subtraction sign exact.
  function automatic int div_ext_width(input int num_w, input int den_w, input int quo_w);
    return ((num_w > den_w + quo_w) ? num_w : den_w + quo_w) + 2;
  endfunction

endpackage

// File: rtl/img_rsz_div_step.sv
// One restoring-division digit: trial-subtract the shifted divisor and keep the result if non-negative.
module img_rsz_div_step #(
  parameter int EXT_W = 42,
  parameter int DEN_W = 32,
  parameter int IDX_W = 3
) (
  input  logic signed [EXT_W-1:0] r_in,
  input  logic        [DEN_W-1:0] den,
  input  logic        [IDX_W-1:0] idx,
  output logic signed [EXT_W-1:0] r_out,
  output logic                    q_bit
);

  logic signed [EXT_W-1:0] den_sh;
  logic signed [EXT_W-1:0] diff;

  always_comb begin
    den_sh = $signed(EXT_W'(den) << idx);
    diff   = r_in - den_sh;
    q_bit  = ~diff[EXT_W-1];
    r_out  = q_bit ? diff : r_in;
  end

endmodule

// File: rtl/img_rsz_div_unit.sv
// Multi-digit restoring divider with remainder, saturation, divide-by-zero and tag passthrough.
// Optional round-to-nearest quotient is enabled by defining IMG_RSZ_DIV_ROUND_EN.
module img_rsz_div_unit
  import img_rsz_div_pkg::*;
#(
  parameter int NUM_W = 40,
  parameter int DEN_W = 32,
  parameter int QUO_W = 8,
  parameter int DPC   = 1,
  parameter int TAG_W = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [NUM_W-1:0] Numinator,
  input  logic [DEN_W-1:0] Denominator,
  input  logic [TAG_W-1:0] TagIn,
  input  logic             BwVld,
  output logic             BwRdy,
  output logic [QUO_W-1:0] Quotient,
  output logic [DEN_W-1:0] Remainder,
  output logic             Ovf,
  output logic             DivZero,
  output logic [TAG_W-1:0] TagOut,
  output logic             FwVld,
  input  logic             FwRdy
);

  localparam int EXT_W = div_ext_width(NUM_W, DEN_W, QUO_W);
  localparam int IDX_W = (QUO_W > 1) ? $clog2(QUO_W) : 1;
  localparam int CMP_W = NUM_W + QUO_W + 1;

  if (!(DPC == 1 || DPC == 2 || DPC == 4) || (QUO_W % DPC != 0)) begin : g_bad_dpc
    $error("img_rsz_div_unit: DPC must be 1, 2 or 4 and divide QUO_W");
  end

  div_state_e              state_q, state_d;
  logic [NUM_W-1:0]        num_q, num_d;
  logic [DEN_W-1:0]        den_q, den_d;
  logic [TAG_W-1:0]        tag_q, tag_d;
  logic signed [EXT_W-1:0] rem_q, rem_d;
  logic [QUO_W-1:0]        quo_q, quo_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  div_flags_t              flags_q, flags_d;

  logic signed [EXT_W-1:0] chain_r [DPC+1];
  logic [DPC-1:0]          chain_q;
  logic [IDX_W-1:0]        step_idx [DPC];
  logic [QUO_W-1:0]        quo_busy;
  logic [CMP_W-1:0]        num_cmp;
  logic [CMP_W-1:0]        den_cmp;

  assign chain_r[0] = rem_q;

  // DPC steps chained combinationally, highest digit first.
  for (genvar gi = 0; gi < DPC; gi++) begin : g_step
    assign step_idx[gi] = idx_q - IDX_W'(gi);
    img_rsz_div_step #(
      .EXT_W(EXT_W),
      .DEN_W(DEN_W),
      .IDX_W(IDX_W)
    ) u_step (
      .r_in (chain_r[gi]),
      .den  (den_q),
      .idx  (step_idx[gi]),
      .r_out(chain_r[gi+1]),
      .q_bit(chain_q[gi])
    );
  end

  always_comb begin
    quo_busy = quo_q;
    for (int k = 0; k < DPC; k++) begin
      quo_busy[step_idx[k]] = chain_q[k];
    end
  end

  assign num_cmp = CMP_W'(num_q);
  assign den_cmp = CMP_W'(den_q) << QUO_W;

`ifdef IMG_RSZ_DIV_ROUND_EN
  logic [EXT_W:0] rem_x2;
  logic           round_up;
  assign rem_x2   = {chain_r[DPC], 1'b0};
  assign round_up = (rem_x2 >= (EXT_W+1)'(den_q));
`endif

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    den_d   = den_q;
    tag_d   = tag_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    idx_d   = idx_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: begin
        if (BwVld) begin
          num_d   = Numinator;
          den_d   = Denominator;
          tag_d   = TagIn;
          quo_d   = '0;
          rem_d   = '0;
          flags_d = '0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (den_q == '0) begin
          flags_d.div_zero = 1'b1;
          quo_d            = '1;
          rem_d            = '0;
          state_d          = DONE;
        end else if (num_cmp >= den_cmp) begin
          flags_d.ovf = 1'b1;
          quo_d       = '1;
          rem_d       = '0;
          state_d     = DONE;
        end else if (num_q == '0) begin
          quo_d   = '0;
          rem_d   = '0;
          state_d = DONE;
        end else begin
          rem_d   = $signed(EXT_W'(num_q));
          idx_d   = IDX_W'(QUO_W - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        rem_d = chain_r[DPC];
        quo_d = quo_busy;
        idx_d = idx_q - IDX_W'(DPC);
        // A zero partial remainder means every lower digit is zero as well.
        if ((chain_r[DPC] == '0) || (idx_q == IDX_W'(DPC - 1))) begin
          state_d = DONE;
`ifdef IMG_RSZ_DIV_ROUND_EN
          if (round_up) begin
            if (&quo_busy) begin
              flags_d.ovf = 1'b1;
            end else begin
              quo_d = quo_busy + QUO_W'(1);
            end
          end
`endif
        end
      end
      DONE: begin
        if (FwRdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      num_q   <= '0;
      den_q   <= '0;
      tag_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      idx_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      den_q   <= den_d;
      tag_q   <= tag_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      idx_q   <= idx_d;
      flags_q <= flags_d;
    end
  end

  assign BwRdy     = (state_q == IDLE);
  assign FwVld     = (state_q == DONE);
  assign Quotient  = quo_q;
  assign Remainder = rem_q[DEN_W-1:0];
  assign Ovf       = flags_q.ovf;
  assign DivZero   = flags_q.div_zero;
  assign TagOut    = tag_q;

endmodule

// File: doc/img_rsz_div_unit.md
Name: img_rsz_div_unit

Overview:
- Parametrised unsigned restoring divider for the image-resizer scale/coordinate path. Successor to the current single-digit ceg divider.
- Adds configurable digits-per-cycle, a remainder output, overflow saturation, divide-by-zero detection, early termination and a sideband tag passthrough.
- Sits between the scale-factor computation and the pixel-coordinate generator, with valid/ready on both sides.

Parameters:
- NUM_W, 40: numerator width.
- DEN_W, 32: denominator width.
- QUO_W, 8: quotient width.
- DPC, 1: quotient digits resolved per clock. Legal values 1, 2, 4; QUO_W mod DPC must be 0. An elaboration-time assertion enforces both.
- TAG_W, 4: sideband tag width, carried unchanged from input to output.

Ports:
- Clk  in  1  clock.
- Rst  in  1  asynchronous active-low reset.
- Numinator  in  NUM_W  dividend, unsigned.
- Denominator  in  DEN_W  divisor, unsigned.
- TagIn  in  TAG_W  sideband tag, captured with the operands.
- BwVld  in  1  operand valid.
- BwRdy  out  1  operand ready.
- Quotient  out  QUO_W  result.
- Remainder  out  DEN_W  final partial remainder.
- Ovf  out  1  quotient overflowed and saturated.
- DivZero  out  1  Denominator was 0.
- TagOut  out  TAG_W  captured tag.
- FwVld  out  1  result valid.
- FwRdy  in  1  result accepted.

Behaviour:
- Reset (Rst=0, asynchronous):
  - state=IDLE.
  - Quotient, Remainder, Ovf, DivZero, TagOut all 0.
  - FwVld=0; BwRdy=1.
  - Any in-flight division is discarded; there is no output for it.
- FSM states: IDLE, CHECK, BUSY, DONE.
  - BwRdy = (state==IDLE).
  - FwVld = (state==DONE).
- IDLE: on BwVld, capture Numinator, Denominator and TagIn, clear quotient and flags, go to CHECK.
- CHECK (1 cycle):
  - D==0: DivZero=1, Quotient=all ones, Remainder=0; go to DONE.
  - Else N >= D<<QUO_W (compared at NUM_W+QUO_W+1 bits): Ovf=1, Quotient=all ones, Remainder=0; go to DONE.
  - Else N==0: Quotient=0, Remainder=0; go to DONE.
  - Else load R=N, digit index i=QUO_W-1, go to BUSY.
- BUSY: each cycle resolves DPC digits, MSB first. Per digit i:
  - T = R - (D<<i).
  - If T>=0: q[i]=1, R=T; else q[i]=0, R unchanged.
  - Chained combinationally DPC times per cycle, then i -= DPC.
  - Internal datapath width is max(NUM_W, DEN_W+QUO_W)+2, signed.
  - Early exit: if R==0 after a cycle's digits, the remaining digits are 0 and the next state is DONE.
  - Normal exit: DONE after the cycle that resolves digit 0.
- Result on exit: Quotient=q, Remainder=R[DEN_W-1:0]. The invariant N = Q*D + R with R < D holds when Ovf=0 and DivZero=0.
- DONE:
  - Outputs are held stable while FwRdy=0.
  - On FwRdy=1, go to IDLE.
  - No new operand is accepted in the same cycle as FwRdy (BwRdy=0 in DONE).
- Latency, BwVld&&BwRdy to FwVld: 1 (capture) + 1 (CHECK) + QUO_W/DPC (BUSY) cycles worst case; 2 cycles for the special cases.
- Throughput: one division per latency+1 cycles with FwRdy held high.
- Operand changes while BwRdy=0 are ignored.

Optional Feature:
- Macro: IMG_RSZ_DIV_ROUND_EN.
- Defined: on exit from BUSY, if 2*R >= D then Quotient = q+1, saturating at all ones. Saturation sets Ovf=1. Remainder still reports the unrounded R. Applies only on the normal and early-exit paths, never to DivZero or Ovf results.
- Undefined: quotient is truncated (floor); no rounding logic is present.

Decomposition:
- Package img_rsz_div_pkg holds:
  - the FSM state enum (IDLE, CHECK, BUSY, DONE);
  - a packed flags struct {Ovf, DivZero};
  - a function computing the internal extended width from NUM_W/DEN_W/QUO_W.
- Sub-module img_rsz_div_step: one combinational restoring step (inputs R, D, digit index; outputs next R, digit bit). Instantiated DPC times in a generate chain.
- The FSM, digit counter and operand/result registers stay in img_rsz_div_unit.

Test Plan:
- DPC=1, N=1000, D=10, FwRdy=1:
  - Q=100, R=0, flags 0.
  - Early exit after digit 2: BUSY lasts 6 cycles; FwVld is asserted 8 cycles after acceptance.
- DPC=2, N=1001, D=10: Q=100, R=1, BUSY lasts exactly 4 cycles. Repeat with DPC=4: 2 cycles, same result.
- N=2600, D=10 (QUO_W=8): Ovf=1, Q=255, R=0, FwVld 2 cycles after acceptance. Repeat with N=5, D=0: DivZero=1, Q=255.
- N=1006, D=10:
  - Q=100, R=6 with the macro undefined.
  - Q=101, R=6 with IMG_RSZ_DIV_ROUND_EN defined.
  - N=2559, D=10 with rounding: Q=255 saturated, Ovf=1.
- Backpressure: FwRdy low for 5 cycles in DONE → Quotient, Remainder and TagOut stable, BwRdy=0. Release → IDLE next cycle. Back-to-back tags 3 then 9 are returned in order.
- Assert Rst=0 mid-BUSY → FwVld=0 and outputs 0 asynchronously. After release, BwRdy=1 and a fresh N=81, D=9 gives Q=9, R=0.
